// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave: frame size, Mode bit positions,
// underrun fill byte and FSM state encodings.
package spi_slave_pkg;

  localparam int SPI_NBITS = 8;
  localparam int SPI_CNT_W = $clog2(SPI_NBITS);

  // Bit positions inside Mode = {CPOL, CPHA}
  localparam int SPI_CPOL = 1;
  localparam int SPI_CPHA = 0;

  // Byte shifted out when a byte starts with nothing pending
  localparam logic [SPI_NBITS-1:0] SPI_FILL = 8'hFF;

  // FSM states
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // MSB-first shift with a new bit entering at the LSB
  function automatic logic [SPI_NBITS-1:0] shift_in(input logic [SPI_NBITS-1:0] r,
                                                    input logic b);
    return {r[SPI_NBITS-2:0], b};
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer followed by an edge register; reports the
// synchronized level plus single-cycle rise/fall strobes.
module spi_slave_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic ff1, ff2, ff3;

  // Metastability chain plus one extra stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1 <= RST_VAL;
      ff2 <= RST_VAL;
      ff3 <= RST_VAL;
    end else begin
      ff1 <= async_in;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  assign level = ff2;
  assign rise  = ff2 & ~ff3;
  assign fall  = ~ff2 & ff3;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four modes, 8-bit MSB-first frames, oversampled in the
// local Clk domain. Single transmit holding register with pending flag.
module spi_slave
  import spi_slave_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [1:0]           Mode,
  input  logic                 SCK,
  input  logic                 SDI,
  input  logic                 CS,
  output logic                 SDO,
  output logic                 SdoEn,
  input  logic [SPI_NBITS-1:0] TxData,
  input  logic                 TxLoad,
  output logic                 TxPend,
  output logic [SPI_NBITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 TxUnderrun,
  output logic                 Busy
);

  logic                 sck_lvl, sck_rise, sck_fall;
  logic                 cs_lvl, cs_rise, cs_fall;
  logic                 sdi_ff1, sdi_ff2;
  logic [0:0]           state;
  logic [1:0]           mode_q;
  logic [SPI_CNT_W-1:0] cnt;
  logic [SPI_NBITS-1:0] rx_sr, tx_sr, hold;
  logic                 first_lead;

  logic cpol, cpha, in_byte, sck_edge, lead, trail, sample, shift;
  logic start, byte_end, reload;
  logic [SPI_NBITS-1:0] reload_val;

  spi_slave_sync #(.RST_VAL(1'b0)) u_sck_sync (
    .clk(Clk), .rst_n(Rst_n), .async_in(SCK),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_slave_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(Clk), .rst_n(Rst_n), .async_in(CS),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  // SDI only needs to be stable, it is sampled on the SCK strobes
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sdi_ff1 <= 1'b0;
      sdi_ff2 <= 1'b0;
    end else begin
      sdi_ff1 <= SDI;
      sdi_ff2 <= sdi_ff1;
    end
  end

  assign cpol     = mode_q[SPI_CPOL];
  assign cpha     = mode_q[SPI_CPHA];
  // Edges seen in the same cycle CS rises belong to an abandoned byte
  assign in_byte  = (state == ST_ACTIVE) & ~cs_rise;
  assign sck_edge = sck_rise | sck_fall;
  // Leading edge moves SCK away from its idle level (CPOL)
  assign lead     = in_byte & sck_edge & (sck_lvl != cpol);
  assign trail    = in_byte & sck_edge & (sck_lvl == cpol);
  assign sample   = cpha ? trail : lead;
  assign shift    = cpha ? lead  : trail;
  assign start    = (state == ST_IDLE) & cs_fall;
  assign byte_end = sample & (cnt == SPI_CNT_W'(SPI_NBITS - 1));
  // CPHA=0: only the 8th trailing edge finds the counter back at 0
  assign reload   = start | (cpha ? byte_end : (shift & (cnt == '0)));
  assign reload_val = TxPend ? hold : SPI_FILL;

  // FSM, bit counter and receive path
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= 2'b00;
      cnt        <= '0;
      rx_sr      <= '0;
      RxData     <= '0;
      RxValid    <= 1'b0;
      first_lead <= 1'b0;
    end else begin
      RxValid <= 1'b0;
      if (cs_rise) begin
        state <= ST_IDLE;
      end else if (start) begin
        state      <= ST_ACTIVE;
        mode_q     <= Mode;
        cnt        <= '0;
        first_lead <= 1'b1;
      end
      if (sample) begin
        rx_sr <= shift_in(rx_sr, sdi_ff2);
        cnt   <= cnt + SPI_CNT_W'(1);
        if (byte_end) begin
          RxData     <= shift_in(rx_sr, sdi_ff2);
          RxValid    <= 1'b1;
          first_lead <= 1'b1;
        end
      end
      // CPHA=1: first leading edge of a byte only presents the MSB
      if (shift && !reload && cpha && first_lead)
        first_lead <= 1'b0;
    end
  end

  // Transmit shift register: reload at byte boundaries, else shift left
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tx_sr <= '0;
    end else if (reload) begin
      tx_sr <= reload_val;
    end else if (shift && !(cpha && first_lead)) begin
      tx_sr <= {tx_sr[SPI_NBITS-2:0], 1'b0};
    end
  end

  // Holding register: a reload consumes it, TxLoad refills and wins on pend
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hold       <= SPI_FILL;
      TxPend     <= 1'b0;
      TxUnderrun <= 1'b0;
    end else begin
      TxUnderrun <= reload & ~TxPend;
      if (reload)
        TxPend <= 1'b0;
      if (TxLoad) begin
        hold   <= TxData;
        TxPend <= 1'b1;
      end
    end
  end

  assign SdoEn = (state == ST_ACTIVE);
  assign SDO   = SdoEn & tx_sr[SPI_NBITS-1];
  assign Busy  = ~cs_lvl;

endmodule
